// File: rtl/shift_collector.sv
// Serial-to-parallel collector: rebuilds WIDTH-bit words from a qualified bit stream, word registered 1 cycle after last bit.
// Single output slot with valid/ready; a word completing into an occupied slot is dropped and flags sticky overrun.
module shift_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             LR,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] Y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_lr;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic             r_overrun;
    logic             w_accept;
    logic             w_done;
    logic             w_slot_free;

    // start takes priority over bit_valid in every state
    assign w_accept    = (r_state == COLLECT) && !start && bit_valid;
    assign w_done      = w_accept && (r_cnt == CW'(WIDTH - 1));
    assign w_slot_free = !r_y_valid || y_ready;
    assign w_sr_shift  = r_lr ? {bit_in, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = COLLECT;
            COLLECT: begin
                if (start)       w_state_nxt = COLLECT;
                else if (w_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == COLLECT);
        Y       = r_y;
        y_valid = r_y_valid;
        overrun = r_overrun;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_lr  <= 1'b0;
        end else if (start) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_lr  <= LR;
        end else if (w_accept) begin
            r_sr  <= w_sr_shift;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_done && w_slot_free) begin
                r_y       <= w_sr_shift;
                r_y_valid <= 1'b1;
            end else if (r_y_valid && y_ready) begin
                r_y_valid <= 1'b0;
            end
            if (w_done && !w_slot_free) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end
endmodule
